// File: rtl/mapper_latch_bank_pkg.sv
// Shared definitions for the mapper latch-port receiver: bank count, entry layout
// and the ROM-size masking helper.
package mapper_latch_bank_pkg;

    localparam int MAPPER_BANKS = 4;
    localparam int MAPPER_IDX_W = 2;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } mapper_latch_entry_t;

    function automatic logic [7:0] mask_bank(input logic [7:0] data, input logic [7:0] mask);
        return data & mask;
    endfunction

endpackage

// File: rtl/mapper_latch_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens on the same edge; otherwise it is ignored and the contents are unchanged.
module mapper_latch_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers are power-of-two wide, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mapper_latch_bank.sv
// Mapper-side receiver: buffers latch-port bank writes, applies them between CPU
// memory cycles, and composes ROM addresses and IO readback from the bank registers.
module mapper_latch_bank
    import mapper_latch_bank_pkg::*;
#(
    parameter int         BANK_W     = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BANK_MASK  = 8'hFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               latch_wr,
    input  logic [1:0]         latch_idx,
    input  logic [7:0]         latch_data,
    input  logic               mem_active,
    input  logic [15:0]        cpu_addr,
    input  logic [1:0]         rd_idx,
    input  logic               ovf_clr,
    output logic [BANK_W+13:0] rom_addr,
    output logic [7:0]         rd_data,
    output logic               pending,
    output logic               overflow
);

    localparam int ENTRY_W = MAPPER_IDX_W + BANK_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    mapper_latch_entry_t strobe;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  pop_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                do_pop;
    logic                drop;
    logic [BANK_W-1:0]   bank [MAPPER_BANKS];

    assign strobe     = '{idx: latch_idx, data: mask_bank(latch_data, BANK_MASK)};
    assign push_entry = {strobe.idx, BANK_W'(strobe.data)};

    // Handshake: latch_wr is a ready-less strobe (dropped if no room); the FIFO
    // output is valid while non-empty and is consumed only when mem_active is low.
    assign do_pop  = !fifo_empty && !mem_active;
    assign drop    = latch_wr && fifo_full && !do_pop;
    assign pending = (fifo_count != '0);

    mapper_latch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (latch_wr),
        .pop       (do_pop),
        .push_data (push_entry),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Reset values give the linear map: bank i holds page i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAPPER_BANKS; i++) bank[i] <= BANK_W'(i);
        end else if (do_pop) begin
            bank[pop_entry[ENTRY_W-1 -: MAPPER_IDX_W]] <= pop_entry[BANK_W-1:0];
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign rom_addr = {bank[cpu_addr[15:14]], cpu_addr[13:0]};
    assign rd_data  = 8'(bank[rd_idx]);

endmodule
